// File: rtl/fp_one_input_arbiter_pkg.sv
// Shared types and helpers for the fp_one_input request arbiter.
// Holds the sequencer state encoding and the index-width helper for the grant pointer.
package fp_one_input_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_e;

    localparam int NCLIENT_MAX = 8;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // A single client still needs a one-bit pointer.
    function automatic int idx_width(input int n);
        return (clog2_f(n) > 1) ? clog2_f(n) : 1;
    endfunction

endpackage

// File: rtl/fp_one_input_arbiter_rr.sv
// Combinational rotating-priority select: the first requester after 'last',
// wrapping from N-1 back to 0, wins.
module fp_one_input_arbiter_rr
    import fp_one_input_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int GW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [GW-1:0] gnt_idx,
    output logic          any
);

    // Walk the clients in priority order; the first hit latches and masks later ones.
    always_comb begin
        int          c;
        logic [GW-1:0] c_s;
        logic        hit_s;
        gnt     = {N{1'b0}};
        gnt_idx = {GW{1'b0}};
        any     = 1'b0;
        c       = 0;
        c_s     = {GW{1'b0}};
        hit_s   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            c        = int'(last) + k;
            c        = (c >= N) ? (c - N) : c;
            c_s      = GW'(c);
            hit_s    = ~any & req[c_s];
            gnt[c_s] = gnt[c_s] | hit_s;
            gnt_idx  = hit_s ? c_s : gnt_idx;
            any      = any | hit_s;
        end
    end

endmodule

// File: rtl/fp_one_input_arbiter.sv
// Shares one single-operand float core among NCLIENT requesters: latches each
// client's operand, issues jobs one at a time in round-robin order, returns results.
module fp_one_input_arbiter
    import fp_one_input_arbiter_pkg::*;
#(
    parameter int NCLIENT = 4,
    parameter int DW      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCLIENT-1:0]    req_start,
    input  logic [NCLIENT*DW-1:0] req_a,
    output logic [NCLIENT-1:0]    req_busy,
    output logic [NCLIENT-1:0]    req_done,
    output logic [DW-1:0]         req_result,
    output logic [NCLIENT-1:0]    err_overrun,
    output logic                  fp_start,
    output logic [DW-1:0]         fp_a,
    input  logic                  fp_done,
    input  logic [DW-1:0]         fp_result
);

    localparam int GW = idx_width(NCLIENT);
    localparam logic [GW-1:0] LAST_RST = GW'(NCLIENT - 1);

    arb_state_e           state_r;
    arb_state_e           state_nx_s;
    logic [NCLIENT-1:0]   pending_r;
    logic [DW-1:0]        opnd_r [NCLIENT];
    logic [NCLIENT-1:0]   err_overrun_r;
    logic [GW-1:0]        grant_r;
    logic [NCLIENT-1:0]   grant_oh_r;
    logic [GW-1:0]        last_r;
    logic                 fp_start_r;
    logic [DW-1:0]        fp_a_r;
    logic [NCLIENT-1:0]   req_done_r;
    logic [DW-1:0]        req_result_r;

    logic [NCLIENT-1:0]   sel_oh_s;
    logic [GW-1:0]        sel_idx_s;
    logic                 sel_any_s;
    logic                 issue_s;
    logic                 finish_s;

    // Arbitration only looks at already-latched requests, never at this cycle's starts.
    fp_one_input_arbiter_rr #(
        .N  (NCLIENT),
        .GW (GW)
    ) u_rr (
        .req     (pending_r),
        .last    (last_r),
        .gnt     (sel_oh_s),
        .gnt_idx (sel_idx_s),
        .any     (sel_any_s)
    );

    // Next-state and job issue/finish decode.
    always_comb begin
        state_nx_s = state_r;
        issue_s    = 1'b0;
        finish_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sel_any_s) begin
                    issue_s    = 1'b1;
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (fp_done) begin
                    finish_s   = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Downstream issue and result return.
    always_ff @(posedge clk) begin
        if (reset) begin
            fp_start_r   <= 1'b0;
            fp_a_r       <= {DW{1'b0}};
            grant_r      <= {GW{1'b0}};
            grant_oh_r   <= {NCLIENT{1'b0}};
            last_r       <= LAST_RST;
            req_done_r   <= {NCLIENT{1'b0}};
            req_result_r <= {DW{1'b0}};
        end else begin
            fp_start_r <= issue_s;
            req_done_r <= finish_s ? grant_oh_r : {NCLIENT{1'b0}};
            if (issue_s) begin
                fp_a_r     <= opnd_r[sel_idx_s];
                grant_r    <= sel_idx_s;
                grant_oh_r <= sel_oh_s;
            end else begin
                fp_a_r <= fp_a_r;
            end
            if (finish_s) begin
                req_result_r <= fp_result;
                last_r       <= grant_r;
            end else begin
                req_result_r <= req_result_r;
            end
        end
    end

    // Per-client capture; a start while still busy is dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r     <= {NCLIENT{1'b0}};
            err_overrun_r <= {NCLIENT{1'b0}};
            for (int i = 0; i < NCLIENT; i++) begin
                opnd_r[i] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NCLIENT; i++) begin
                if (req_start[i] && !pending_r[i]) begin
                    pending_r[i] <= 1'b1;
                    opnd_r[i]    <= req_a[i*DW +: DW];
                end else if (finish_s && grant_oh_r[i]) begin
                    pending_r[i] <= 1'b0;
                end else begin
                    pending_r[i] <= pending_r[i];
                end
                if (req_start[i] && pending_r[i]) begin
                    err_overrun_r[i] <= 1'b1;
                end else begin
                    err_overrun_r[i] <= err_overrun_r[i];
                end
            end
        end
    end

    assign req_busy    = pending_r;
    assign req_done    = req_done_r;
    assign req_result  = req_result_r;
    assign err_overrun = err_overrun_r;
    assign fp_start    = fp_start_r;
    assign fp_a        = fp_a_r;

endmodule
